// File: rtl/sfifo_wf.sv
// rtl/sfifo_wf.sv - single-clock FIFO on a write-first dual-port RAM with level and flags
module sfifo_wf #(
    parameter int DEPTH         = 4,
    parameter int WIDTH         = 32,
    parameter int AFULL_THRESH  = 12,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             afull,
    output logic             overflow,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             empty,
    output logic             aempty,
    output logic             underflow,
    output logic [DEPTH:0]   level
);

    localparam logic [DEPTH:0]   CAP     = (DEPTH+1)'(2**DEPTH);
    localparam logic [DEPTH:0]   AF_T    = (DEPTH+1)'(AFULL_THRESH);
    localparam logic [DEPTH:0]   AE_T    = (DEPTH+1)'(AEMPTY_THRESH);
    localparam logic [DEPTH:0]   LVL_ONE = (DEPTH+1)'(1);
    localparam logic [DEPTH-1:0] PTR_ONE = DEPTH'(1);

    logic [WIDTH-1:0] mem [0:(2**DEPTH)-1];
    logic [DEPTH-1:0] wr_ptr;
    logic [DEPTH-1:0] rd_ptr;
    logic [DEPTH:0]   level_nxt;
    logic             wr_acc;
    logic             rd_acc;

    // Acceptance uses the registered flags, so a read on empty or a write on
    // full is rejected even when the opposite port is active in the same cycle.
    assign wr_acc = wr_en && !full  && !srst;
    assign rd_acc = rd_en && !empty && !srst;

    always_comb begin
        level_nxt = level;
        if (wr_acc && !rd_acc) begin
            level_nxt = level + LVL_ONE;
        end else if (rd_acc && !wr_acc) begin
            level_nxt = level - LVL_ONE;
        end
    end

    // Storage array carries no reset; contents survive srst.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            full       <= 1'b0;
            empty      <= 1'b1;
            afull      <= (AFULL_THRESH == 0);
            aempty     <= 1'b1;
            dout       <= '0;
            dout_valid <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + PTR_ONE;
                dout   <= mem[rd_ptr];
            end
            level      <= level_nxt;
            full       <= (level_nxt == CAP);
            empty      <= (level_nxt == '0);
            afull      <= (level_nxt >= AF_T);
            aempty     <= (level_nxt <= AE_T);
            dout_valid <= rd_acc;
            overflow   <= wr_en && full;
            underflow  <= rd_en && empty;
        end
    end

endmodule

// File: tb/tb_sfifo_wf.sv
// tb/tb_sfifo_wf.sv - randomized queue-model bench for sfifo_wf
module tb_sfifo_wf;

    logic        clk = 1'b0;
    logic        srst = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] din = '0;
    logic        rd_en = 1'b0;
    logic        full, afull, overflow, empty, aempty, underflow, dout_valid;
    logic [31:0] dout;
    logic [4:0]  level;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    logic [31:0] q[$];
    logic [31:0] m_dout;
    logic        m_dv, m_ov, m_uf;

    always #5 clk = ~clk;

    sfifo_wf #(.DEPTH(4), .WIDTH(32), .AFULL_THRESH(12), .AEMPTY_THRESH(2)) dut (
        .clk(clk), .srst(srst), .wr_en(wr_en), .din(din), .full(full),
        .afull(afull), .overflow(overflow), .rd_en(rd_en), .dout(dout),
        .dout_valid(dout_valid), .empty(empty), .aempty(aempty),
        .underflow(underflow), .level(level)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: a plain queue of stored words with capacity 16.
    always @(posedge clk) begin
        bit wa, ra;
        if (srst) begin
            q.delete();
            m_dout = '0;
            m_dv = 1'b0;
            m_ov = 1'b0;
            m_uf = 1'b0;
        end else begin
            wa = wr_en && (q.size() < 16);
            ra = rd_en && (q.size() > 0);
            m_ov = wr_en && !wa;
            m_uf = rd_en && !ra;
            m_dv = ra;
            if (ra) m_dout = q.pop_front();
            if (wa) q.push_back(din);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_level",     32'(level),      32'(q.size()));
            chk("m_full",      32'(full),       32'(q.size() == 16));
            chk("m_empty",     32'(empty),      32'(q.size() == 0));
            chk("m_afull",     32'(afull),      32'(q.size() >= 12));
            chk("m_aempty",    32'(aempty),     32'(q.size() <= 2));
            chk("m_dout",      dout,            m_dout);
            chk("m_dout_valid",32'(dout_valid), 32'(m_dv));
            chk("m_overflow",  32'(overflow),   32'(m_ov));
            chk("m_underflow", 32'(underflow),  32'(m_uf));
        end
    end

    // Called at a falling edge; returns at the next falling edge.
    task automatic cyc(input logic s, input logic w, input logic [31:0] d, input logic r);
        srst = s;
        wr_en = w;
        din = d;
        rd_en = r;
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] in_seq[$];
        logic [31:0] out_seq[$];
        int nw, iter, ovs;
        logic w, r;

        @(negedge clk);
        // 1 reset
        cyc(1, 1, 32'hDEAD, 1);
        chk_en = 1'b1;
        cyc(1, 0, 0, 0);
        chk("rst_level", 32'(level), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_aempty", 32'(aempty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_dout", dout, 0);

        // 2 fill
        for (int i = 0; i < 16; i++) begin
            cyc(0, 1, 32'h1000 + 32'(i), 0);
            if (i == 10) chk("fill_afull11", 32'(afull), 0);
            if (i == 11) chk("fill_afull12", 32'(afull), 1);
        end
        chk("fill_full", 32'(full), 1);
        chk("fill_level", 32'(level), 16);
        cyc(0, 1, 32'hBAD0, 0);
        chk("fill_overflow", 32'(overflow), 1);
        chk("fill_level_hold", 32'(level), 16);
        cyc(0, 0, 0, 0);
        chk("fill_overflow_clear", 32'(overflow), 0);

        // 3 drain
        for (int i = 0; i < 16; i++) begin
            cyc(0, 0, 0, 1);
            chk("drain_dv", 32'(dout_valid), 1);
            chk("drain_data", dout, 32'h1000 + 32'(i));
        end
        chk("drain_empty", 32'(empty), 1);
        cyc(0, 0, 0, 1);
        chk("drain_underflow", 32'(underflow), 1);
        chk("drain_dout_hold", dout, 32'h100F);
        chk("drain_dv_none", 32'(dout_valid), 0);

        // empty with simultaneous write and read: write wins
        cyc(0, 1, 32'h5555, 1);
        chk("empty_wr_rd_uf", 32'(underflow), 1);
        chk("empty_wr_rd_level", 32'(level), 1);
        cyc(0, 0, 0, 1);
        chk("empty_wr_rd_data", dout, 32'h5555);

        // 4 concurrent
        for (int i = 0; i < 5; i++) cyc(0, 1, $urandom, 0);
        for (int i = 0; i < 10; i++) begin
            cyc(0, 1, $urandom, 1);
            chk("conc_level", 32'(level), 5);
        end
        while (q.size() < 16) cyc(0, 1, $urandom, 0);
        cyc(0, 1, $urandom, 1);
        chk("full_wr_rd_level", 32'(level), 15);
        chk("full_wr_rd_ov", 32'(overflow), 1);
        chk("full_wr_rd_dv", 32'(dout_valid), 1);
        for (int i = 0; i < 20 && q.size() > 0; i++) cyc(0, 0, 0, 1);

        // 5 wrap: 40 words, level held within 1..8
        nw = 0;
        ovs = 0;
        iter = 0;
        while ((nw < 40 || q.size() > 0) && iter < 600) begin
            iter++;
            w = (nw < 40) && (q.size() < 8) && ($urandom_range(0, 1) == 1);
            if (nw == 0) w = 1'b1;
            r = ($urandom_range(0, 2) != 0) && (q.size() > 0);
            if (nw < 40 && q.size() <= 1 && !w) r = 1'b0;
            cyc(0, w, 32'hC000 + 32'(nw), r);
            if (w) begin
                in_seq.push_back(32'hC000 + 32'(nw));
                nw++;
            end
            if (dout_valid) out_seq.push_back(dout);
            if (overflow || underflow) ovs++;
        end
        chk("wrap_done", 32'(iter < 600), 1);
        chk("wrap_count", 32'(out_seq.size()), 40);
        chk("wrap_no_ovuf", 32'(ovs), 0);
        for (int i = 0; i < 40 && i < out_seq.size(); i++)
            chk("wrap_data", out_seq[i], in_seq[i]);

        // 6 reset mid-operation
        for (int i = 0; i < 7; i++) cyc(0, 1, 32'h7700 + 32'(i), 0);
        chk("pre_rst_level", 32'(level), 7);
        cyc(1, 1, 32'h7777, 1);
        chk("mid_rst_level", 32'(level), 0);
        chk("mid_rst_empty", 32'(empty), 1);
        chk("mid_rst_dv", 32'(dout_valid), 0);
        cyc(0, 1, 32'hABCD, 0);
        cyc(0, 0, 0, 1);
        chk("post_rst_dv", 32'(dout_valid), 1);
        chk("post_rst_data", dout, 32'hABCD);
        chk("post_rst_empty", 32'(empty), 1);

        // random soak
        for (int i = 0; i < 300; i++)
            cyc(($urandom_range(0, 99) == 0), $urandom_range(0, 1), $urandom, $urandom_range(0, 1));

        cyc(0, 0, 0, 0);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
